// File: rtl/tx_feeder_pkg.sv
// Shared definitions for the UART transmit feeder: FSM state encodings and
// default character width / FIFO depth.
package tx_feeder_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_START  = 2'b01,
    ST_ACTIVE = 2'b10
  } feeder_state_e;

endpackage

// File: rtl/tx_feeder_sync_fifo.sv
// Show-ahead synchronous FIFO with count-derived full/empty and a flush that
// can optionally keep the in-flight head entry.
module tx_feeder_sync_fifo
  import tx_feeder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  input  logic              flush,
  input  logic              keep_head,
  output logic [DATA_W-1:0] head,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full
);

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_ok;

  // Flush wins over a same-cycle write; writes while full are dropped.
  assign wr_ok = wr_en && !full && !flush;
  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);
  assign head  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      if (keep_head) begin
        // Keep only the launched head; if it pops now the FIFO ends empty.
        wr_ptr <= rd_ptr + PTR_ONE;
        count  <= pop ? '0 : CNT_ONE;
        if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      end else begin
        wr_ptr <= rd_ptr;
        count  <= '0;
      end
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tx_feeder.sv
// Feeds buffered host bytes to the UART Tx module one character at a time,
// popping each only on the rising edge of the Tx done pulse.
module tx_feeder
  import tx_feeder_pkg::*;
#(
  parameter int MAX_UART_DATA_W = DEF_DATA_W,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int FIFO_ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       tx_en_i,
  input  logic                       flush_i,
  input  logic                       wr_valid_i,
  input  logic [MAX_UART_DATA_W-1:0] wr_data_i,
  output logic                       wr_ready_o,
  input  logic                       tx_busy_i,
  input  logic                       tx_done_i,
  output logic                       tx_start_o,
  output logic [MAX_UART_DATA_W-1:0] tx_data_o,
  output logic [FIFO_ADDR_W:0]       fifo_count_o,
  output logic                       fifo_empty_o,
  output logic                       fifo_full_o
);

  feeder_state_e state;
  logic          done_q;
  logic          done_rise;
  logic          pop;
  logic          keep_head;

  assign done_rise  = tx_done_i && !done_q;
  assign pop        = (state == ST_ACTIVE) && done_rise;
  assign keep_head  = (state != ST_IDLE);
  assign wr_ready_o = !fifo_full_o;

  tx_feeder_sync_fifo #(
    .DATA_W (MAX_UART_DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (FIFO_ADDR_W)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .wr_en     (wr_valid_i),
    .wr_data   (wr_data_i),
    .pop       (pop),
    .flush     (flush_i),
    .keep_head (keep_head),
    .head      (tx_data_o),
    .count     (fifo_count_o),
    .empty     (fifo_empty_o),
    .full      (fifo_full_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      tx_start_o <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= tx_done_i;
      case (state)
        ST_IDLE: begin
          if (tx_en_i && !fifo_empty_o && !tx_busy_i) begin
            state      <= ST_START;
            tx_start_o <= 1'b1;
          end
        end
        ST_START: begin
          if (tx_busy_i) begin
            state      <= ST_ACTIVE;
            tx_start_o <= 1'b0;
          end else if (!tx_en_i) begin
            state      <= ST_IDLE;
            tx_start_o <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (done_rise) state <= ST_IDLE;
        end
        default: begin
          state      <= ST_IDLE;
          tx_start_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_feeder.sv
// Directed bench for tx_feeder: launch/pop handshake, full FIFO with wrap,
// flushes, simultaneous write/pop, enable drop in Start and async reset.
module tb_tx_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_en;
  logic       flush;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [4:0] fifo_count;
  logic       fifo_empty;
  logic       fifo_full;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  tx_feeder dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tx_en_i      (tx_en),
    .flush_i      (flush),
    .wr_valid_i   (wr_valid),
    .wr_data_i    (wr_data),
    .wr_ready_o   (wr_ready),
    .tx_busy_i    (tx_busy),
    .tx_done_i    (tx_done),
    .tx_start_o   (tx_start),
    .tx_data_o    (tx_data),
    .fifo_count_o (fifo_count),
    .fifo_empty_o (fifo_empty),
    .fifo_full_o  (fifo_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    step();
    wr_valid = 1'b0;
  endtask

  // Simple Tx module: accept a start, stay busy, then a 4-clk done pulse.
  task automatic tx_model(output logic [7:0] b);
    int n = 0;
    while (!tx_start && n < 50) begin
      step();
      n++;
    end
    if (!tx_start) begin
      chk("start_wait", 32'(tx_start), 1);
      b = 8'h00;
    end else begin
      b = tx_data;
      tx_busy = 1'b1;
      repeat (3) step();
      tx_busy = 1'b0;
      tx_done = 1'b1;
      repeat (4) step();
      tx_done = 1'b0;
      step();
    end
  endtask

  logic [7:0] got;

  initial begin
    rst_n = 1'b0; tx_en = 1'b0; flush = 1'b0; wr_valid = 1'b0;
    wr_data = 8'h00; tx_busy = 1'b0; tx_done = 1'b0;
    step();
    chk("rst_start", 32'(tx_start), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_empty", 32'(fifo_empty), 1);
    chk("rst_full", 32'(fifo_full), 0);
    chk("rst_ready", 32'(wr_ready), 1);
    rst_n = 1'b1;
    step();

    // Single character through the full handshake
    tx_en = 1'b1;
    push(8'hA5);
    chk("a5_count", 32'(fifo_count), 1);
    chk("a5_no_start_yet", 32'(tx_start), 0);
    step();
    chk("a5_start", 32'(tx_start), 1);
    chk("a5_data", 32'(tx_data), 32'hA5);
    tx_busy = 1'b1;
    step();
    chk("a5_active_start", 32'(tx_start), 0);
    chk("a5_active_data", 32'(tx_data), 32'hA5);
    tx_done = 1'b1;
    step();
    tx_busy = 1'b0;
    chk("a5_pop_count", 32'(fifo_count), 0);
    repeat (15) step();
    chk("a5_long_done_count", 32'(fifo_count), 0);
    chk("a5_long_done_empty", 32'(fifo_empty), 1);
    chk("a5_long_done_start", 32'(tx_start), 0);
    tx_done = 1'b0;
    step();

    // Fill to full (pointers start at 1, so both wrap), overflow write ignored
    tx_en = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("full_flag", 32'(fifo_full), 1);
    chk("full_ready", 32'(wr_ready), 0);
    chk("full_count", 32'(fifo_count), 16);
    push(8'hFF);
    chk("ovf_count", 32'(fifo_count), 16);
    chk("ovf_head", 32'(tx_data), 0);
    tx_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tx_model(got);
      chk($sformatf("order_%0d", i), 32'(got), 32'(i));
    end
    step();
    chk("drain_empty", 32'(fifo_empty), 1);
    chk("drain_start", 32'(tx_start), 0);

    // Flush in Active keeps only the in-flight head
    tx_en = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
    tx_en = 1'b1;
    step();
    chk("fl_start", 32'(tx_start), 1);
    tx_busy = 1'b1;
    step();
    chk("fl_pre_count", 32'(fifo_count), 5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_count", 32'(fifo_count), 1);
    chk("fl_head", 32'(tx_data), 32'h10);
    tx_busy = 1'b0;
    tx_done = 1'b1;
    step();
    chk("fl_pop_count", 32'(fifo_count), 0);
    repeat (5) step();
    chk("fl_no_relaunch", 32'(tx_start), 0);
    tx_done = 1'b0;
    step();

    // Flush coinciding with pop empties the FIFO
    tx_en = 1'b0;
    push(8'h21);
    push(8'h22);
    tx_en = 1'b1;
    step();
    tx_busy = 1'b1;
    step();
    flush = 1'b1;
    tx_done = 1'b1;
    step();
    flush = 1'b0; tx_done = 1'b0; tx_busy = 1'b0;
    chk("flpop_count", 32'(fifo_count), 0);
    tx_en = 1'b0;
    push(8'h23);
    chk("flpop_new_head", 32'(tx_data), 32'h23);
    chk("flpop_new_count", 32'(fifo_count), 1);
    // Flush in Idle drops everything, including a same-cycle write
    flush = 1'b1; wr_valid = 1'b1; wr_data = 8'h99;
    step();
    flush = 1'b0; wr_valid = 1'b0;
    chk("flidle_count", 32'(fifo_count), 0);
    chk("flidle_empty", 32'(fifo_empty), 1);

    // Write on the same clk as done_rise
    push(8'h31); push(8'h32); push(8'h33);
    chk("sim_pre_count", 32'(fifo_count), 3);
    tx_en = 1'b1;
    step();
    tx_busy = 1'b1;
    step();
    tx_done = 1'b1; wr_valid = 1'b1; wr_data = 8'h3C;
    step();
    wr_valid = 1'b0; tx_done = 1'b0; tx_busy = 1'b0;
    chk("sim_count", 32'(fifo_count), 3);
    chk("sim_head", 32'(tx_data), 32'h32);
    tx_model(got); chk("sim_b0", 32'(got), 32'h32);
    tx_model(got); chk("sim_b1", 32'(got), 32'h33);
    tx_model(got); chk("sim_b2", 32'(got), 32'h3C);
    step();
    chk("sim_empty", 32'(fifo_empty), 1);

    // Enable dropped in Start returns to Idle without a pop
    tx_en = 1'b0;
    push(8'h77);
    tx_en = 1'b1;
    step();
    chk("drop_start", 32'(tx_start), 1);
    tx_en = 1'b0;
    step();
    chk("drop_idle_start", 32'(tx_start), 0);
    chk("drop_count", 32'(fifo_count), 1);
    chk("drop_head", 32'(tx_data), 32'h77);
    step();
    chk("drop_stay_idle", 32'(tx_start), 0);
    flush = 1'b1;
    step();
    flush = 1'b0;

    // Asynchronous reset mid-Active, then mid-Start
    tx_en = 1'b1;
    push(8'h5A);
    step();
    tx_busy = 1'b1;
    step();
    push(8'h5B);
    chk("ra_pre_count", 32'(fifo_count), 2);
    rst_n = 1'b0;
    #2;
    chk("ra_start", 32'(tx_start), 0);
    chk("ra_count", 32'(fifo_count), 0);
    chk("ra_empty", 32'(fifo_empty), 1);
    chk("ra_data", 32'(tx_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tx_busy = 1'b0;
    step();
    chk("ra_after_start", 32'(tx_start), 0);
    push(8'h66);
    step();
    chk("ra_relaunch", 32'(tx_start), 1);
    chk("ra_relaunch_data", 32'(tx_data), 32'h66);
    rst_n = 1'b0;
    #2;
    chk("rs_start_async", 32'(tx_start), 0);
    chk("rs_count", 32'(fifo_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/tx_feeder.md
Name: tx_feeder

Overview:
- Upstream stage of the UART transmitter.
- Buffers host bytes in a small synchronous FIFO and drives tx_start/tx_data into the Tx module one character at a time.
- Tracks the Tx module's busy/done status so no character is dropped or sent twice.
- Sits between the register/bus interface and the Tx module, in the same clock domain.

Parameters:
MAX_UART_DATA_W, 8, width of one UART character
FIFO_DEPTH, 16, number of FIFO entries (power of two, >=2)
FIFO_ADDR_W, 4, log2(FIFO_DEPTH)

Ports:
clk_i  in  1  top clock
rst_ni  in  1  reset, asynchronous, active-low
tx_en_i  in  1  enable; feeder only launches characters while high
flush_i  in  1  discard queued, not-yet-launched characters
wr_valid_i  in  1  host write request
wr_data_i  in  MAX_UART_DATA_W  host write data
wr_ready_o  out  1  FIFO can accept (=!fifo_full_o)
tx_busy_i  in  1  Tx module busy status
tx_done_i  in  1  Tx module done pulse (high for one baud tick, i.e. several clk)
tx_start_o  out  1  start request to Tx module
tx_data_o  out  MAX_UART_DATA_W  character to Tx module (FIFO head)
fifo_count_o  out  FIFO_ADDR_W+1  entries held, including in-flight head
fifo_empty_o  out  1  count==0
fifo_full_o  out  1  count==FIFO_DEPTH

Behaviour:
- One clock domain. Reset is asynchronous and active-low: clk_i, rst_ni. All state is cleared on rst_ni low.
- Reset values: tx_start_o=0, tx_data_o=0, fifo_count_o=0, fifo_empty_o=1, fifo_full_o=0, wr_ready_o=1. FSM starts in Idle. Pointers and done_q are 0.
- Write: accepted on the clk edge where wr_valid_i && wr_ready_o. Data is written at wr_ptr, wr_ptr increments modulo FIFO_DEPTH, count +1. A write while full is ignored and does not corrupt state.
- Show-ahead read: tx_data_o = mem[rd_ptr] combinationally. It is 0 when empty.
- done edge: done_q registers tx_done_i. done_rise = tx_done_i && !done_q. Only done_rise counts; a multi-cycle done pulse pops exactly once.
- FSM (registered state):
  - Idle: tx_start_o=0. If tx_en_i && !empty && !tx_busy_i, go to Start.
  - Start: tx_start_o=1. tx_data_o must stay stable in this state.
    - If tx_busy_i=1, go to Active.
    - Else if tx_en_i=0, return to Idle with no pop.
  - Active: tx_start_o=0; tx_data_o is held (head not popped). On done_rise: pop (rd_ptr+1 mod DEPTH, count -1) and go to Idle. tx_en_i is ignored.
- Back-to-back launches: earliest relaunch is the clk after the pop. Idle waits for tx_busy_i=0.
- Simultaneous write and pop: count unchanged, both pointers advance.
- Write to an empty FIFO: the entry is visible on tx_data_o the clk after acceptance. Launch (Idle->Start) happens the same edge at the earliest, so Start is entered the clk after the write.
- flush_i (single clk, priority over a same-cycle write; the write is dropped):
  - In Idle: wr_ptr<=rd_ptr, count<=0.
  - In Start or Active: wr_ptr<=rd_ptr+1, count<=1. The in-flight head is kept and popped normally on done.
  - A flush coinciding with a pop in Active gives count=0, wr_ptr=rd_ptr=old rd_ptr+1.
- Wrap-around: pointers are FIFO_ADDR_W bits and wrap naturally. Full/empty are derived from count, not pointers.
- Reset mid-transmission: everything clears immediately. tx_start_o drops asynchronously. Any partial character in the Tx module is that module's concern.

Decomposition:
- Shared header uart_defs.vh holds:
  - feeder state encodings (Idle=2'b00, Start=2'b01, Active=2'b10)
  - default MAX_UART_DATA_W / FIFO_DEPTH constants
- Natural sub-module: uart_sync_fifo. It covers storage, pointers, count, full/empty, and flush-keep-head input.
- tx_feeder holds the FSM, done edge detect, and the launch/pop logic.

Test Plan:
- Reset with rst_ni=0 mid-Active -> tx_start_o=0, fifo_count_o=0, fifo_empty_o=1 with no clk edge; FSM Idle after release.
- tx_en_i=1, write 0xA5 -> Start entered the next clk with tx_data_o=0xA5. Then tx_busy_i=1 -> tx_start_o=0. Then tx_done_i high 16 clk -> exactly one pop, count 1->0.
- Write 16 bytes 0x00..0x0F with tx_en_i=0 -> fifo_full_o=1, wr_ready_o=0. A 17th write (0xFF) is ignored. Enable and model Tx -> bytes emitted 0x00..0x0F in order, pointer wrap verified.
- Active with count=5, pulse flush_i -> count=1. Head is retained and popped on done; no further tx_start_o.
- Same clk as done_rise with count=3, write 0x3C -> count stays 3; 0x3C is the last entry.
- In Start with tx_busy_i=0, drop tx_en_i -> return to Idle, tx_start_o=0, count unchanged.
